// File: rtl/seg_pkg.sv
// seg_pkg: seven-segment pattern and BCD code constants shared by the scan reader
package seg_pkg;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_ERR = 4'hE;
  function automatic logic is_onehot4(input logic [3:0] v);
    return v != 4'd0 && (v & (v - 4'd1)) == 4'd0;
  endfunction
endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: maps a g..a segment pattern to a BCD nibble plus an error flag
module seg7_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] bcd,
  output logic       err
);
  always_comb begin
    bcd = BCD_ERR;
    err = 1'b1;
    case (pattern)
      SEG_0:     begin bcd = 4'd0; err = 1'b0; end
      SEG_1:     begin bcd = 4'd1; err = 1'b0; end
      SEG_2:     begin bcd = 4'd2; err = 1'b0; end
      SEG_3:     begin bcd = 4'd3; err = 1'b0; end
      SEG_4:     begin bcd = 4'd4; err = 1'b0; end
      SEG_5:     begin bcd = 4'd5; err = 1'b0; end
      SEG_6:     begin bcd = 4'd6; err = 1'b0; end
      SEG_7:     begin bcd = 4'd7; err = 1'b0; end
      SEG_8:     begin bcd = 4'd8; err = 1'b0; end
      SEG_9:     begin bcd = 4'd9; err = 1'b0; end
      SEG_BLANK: begin bcd = BCD_BLANK; err = 1'b0; end
      default:   begin bcd = BCD_ERR; err = 1'b1; end
    endcase
  end
endmodule

// File: rtl/seg_scan_reader.sv
// seg_scan_reader: samples a multiplexed 7-segment display bus and captures each
// digit once its enable and pattern have been stable for STABLE_CYCLES samples
module seg_scan_reader
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_seg,
  input  logic [3:0]  i_dig,
  input  logic        i_clear,
  output logic [15:0] o_bcd,
  output logic [3:0]  o_dp,
  output logic [3:0]  o_err,
  output logic        o_frame_valid
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] CAPTURED = 2'd2;
  localparam logic [3:0] LAST = 4'(STABLE_CYCLES - 1);
  logic [11:0] sync1, sync2, prev;
  logic [1:0] state;
  logic [3:0] count, mask, dig, dec_bcd;
  logic dec_err, change, capture, done;
  assign dig = sync2[11:8];
  assign change = sync2 != prev;
  assign capture = state == SETTLE && !change && count == LAST;
  // a frame completes only when this capture fills the mask and no clear overrides it
  assign done = capture && !i_clear && (mask | dig) == 4'hF;
  seg7_pattern_decode u_dec (
    .pattern(sync2[6:0]),
    .bcd    (dec_bcd),
    .err    (dec_err)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev <= '0;
      state <= IDLE;
      count <= '0;
      mask <= '0;
      o_bcd <= 16'hFFFF;
      o_dp <= '0;
      o_err <= '0;
      o_frame_valid <= 1'b0;
    end else begin
      sync1 <= {i_dig, i_seg};
      sync2 <= sync1;
      prev <= sync2;
      if (change) begin
        state <= is_onehot4(dig) ? SETTLE : IDLE;
        count <= '0;
      end else if (capture) state <= CAPTURED;
      else if (state == SETTLE) count <= count + 4'd1;
      o_frame_valid <= done;
      mask <= (i_clear || done) ? 4'd0 : capture ? (mask | dig) : mask;
      for (int n = 0; n < 4; n++)
        if (capture && dig[n]) begin
          o_bcd[4*n +: 4] <= dec_bcd;
          o_dp[n] <= sync2[7];
          o_err[n] <= dec_err;
        end
    end
  end
endmodule

// File: tb/tb_seg_scan_reader.sv
// tb_seg_scan_reader: randomized + directed scoreboard bench against a run-length reference model
module tb_seg_scan_reader;
  localparam int S = 3;
  logic clk = 1'b0, rst_n = 1'b0, i_clear = 1'b0;
  logic [7:0] i_seg = '0;
  logic [3:0] i_dig = '0;
  logic [15:0] o_bcd;
  logic [3:0] o_dp, o_err;
  logic o_frame_valid;
  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic [3:0]  err;
    logic        fv;
  } obs_t;
  obs_t q[$];
  obs_t m;
  logic [3:0] mmask;
  logic [11:0] last_val;
  int last_run;
  logic [11:0] dv[$];
  int dr[$];
  int checks = 0, fails = 0;
  logic [6:0] pats [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  seg_scan_reader #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .i_seg(i_seg), .i_dig(i_dig), .i_clear(i_clear),
    .o_bcd(o_bcd), .o_dp(o_dp), .o_err(o_err), .o_frame_valid(o_frame_valid)
  );

  always #5 clk = ~clk;

  function automatic void decode(input logic [6:0] p, output logic [3:0] b, output logic e);
    b = 4'hE;
    e = 1'b1;
    if (p == 7'h00) begin b = 4'hF; e = 1'b0; end
    for (int i = 0; i < 10; i++)
      if (pats[i] == p) begin b = 4'(i); e = 1'b0; end
  endfunction

  function automatic void model_reset();
    m = '{bcd: 16'hFFFF, dp: 4'h0, err: 4'h0, fv: 1'b0};
    mmask = '0;
    last_val = '0;
    last_run = 0;
    dv = '{12'h0, 12'h0};
    dr = '{0, 0};
  endfunction

  // a digit is taken when its sample run, seen two synchronizer stages late, reaches S+1
  function automatic void model_edge();
    logic [11:0] v, ov;
    int r, orr, idx;
    logic [3:0] b, d, nm;
    logic e;
    if (!rst_n) begin model_reset(); return; end
    v = {i_dig, i_seg};
    r = (v == last_val) ? last_run + 1 : 1;
    last_val = v;
    last_run = r;
    dv.push_back(v);
    dr.push_back(r);
    ov = dv.pop_front();
    orr = dr.pop_front();
    d = ov[11:8];
    m.fv = 1'b0;
    if (orr == S + 1 && $onehot(d)) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (d[i]) idx = i;
      decode(ov[6:0], b, e);
      m.bcd[4*idx +: 4] = b;
      m.dp[idx] = ov[7];
      m.err[idx] = e;
      nm = mmask | d;
      if (i_clear) mmask = '0;
      else if (nm == 4'hF) begin m.fv = 1'b1; mmask = '0; end
      else mmask = nm;
    end else if (i_clear) mmask = '0;
  endfunction

  task automatic step(input logic [3:0] d, input logic [7:0] s, input logic c);
    i_dig = d;
    i_seg = s;
    i_clear = c;
    @(posedge clk);
    model_edge();
    q.push_back(m);
    #1;
  endtask

  task automatic hold(input logic [3:0] d, input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) step(d, s, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    model_reset();
    q.push_back(m);
    step(4'h0, 8'h00, 1'b0);
    step(4'h0, 8'h00, 1'b0);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    obs_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({o_bcd, o_dp, o_err, o_frame_valid} !== e) begin
        fails++;
        $display("FAIL outputs t=%0t got bcd=%h dp=%b err=%b fv=%b expected bcd=%h dp=%b err=%b fv=%b",
                 $time, o_bcd, o_dp, o_err, o_frame_valid, e.bcd, e.dp, e.err, e.fv);
      end
    end
  end

  initial begin
    logic [7:0] seg_list [4] = '{8'h06, 8'h4F, 8'h66, 8'hED};
    model_reset();
    rst_n = 1'b0;
    hold(4'h0, 8'h00, 3);
    rst_n = 1'b1;
    hold(4'b0001, 8'h5B, 8);
    for (int i = 0; i < 4; i++) hold(4'(1 << i), seg_list[i], 6);
    for (int i = 0; i < 20; i++) step(4'b0001, (i / 2) % 2 ? 8'h06 : 8'h3F, 1'b0);
    hold(4'b0100, 8'h49, 6);
    hold(4'b0100, 8'h00, 6);
    hold(4'b0011, 8'h7F, 10);
    hold(4'b0100, 8'h3F, 3);
    do_reset();
    for (int i = 0; i < 3; i++) hold(4'(1 << i), 8'h7D, 6);
    for (int i = 0; i < 6; i++) step(4'b1000, 8'h07, 1'(i == S + 2));
    for (int i = 0; i < 4; i++) hold(4'(1 << i), 8'h6F, 6);
    for (int k = 0; k < 200; k++) begin
      logic [3:0] d;
      logic [7:0] s;
      int n;
      d = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      s = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {1'($urandom), pats[$urandom_range(0, 9)]};
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) step(d, s, 1'($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 60) == 0) do_reset();
    end
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/seg_scan_reader.md
SEG_SCAN_READER -- requirements
Module: seg_scan_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 3, meaning the number of consecutive identical synchronized samples required before capture; legal range 1..15.
REQ-002 SHALL have port clk  input  1  the single clock; all flops rise-edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_seg  input  8  segment bus from the multiplexed display: bit7 = dp, bits6:0 = g..a, active-high.
REQ-005 SHALL have port i_dig  input  4  digit enables, active-high, expected one-hot.
REQ-006 SHALL have port i_clear  input  1  synchronous clear of the frame-tracking mask.
REQ-007 SHALL have port o_bcd  output  16  four captured digits; nibble n belongs to i_dig[n].
REQ-008 SHALL have port o_dp  output  4  captured dp bit per digit.
REQ-009 SHALL have port o_err  output  4  per-digit flag for an unrecognised segment pattern.
REQ-010 SHALL have port o_frame_valid  output  1  one-cycle pulse when all four digits have been captured since the last frame.

Function
REQ-011 SHALL pass i_seg and i_dig through a two-flop synchronizer before any other use.
REQ-012 SHALL run a state machine with states IDLE, SETTLE, CAPTURED; the counter width is 4 bits.
REQ-013 SHALL compare the synchronized {i_dig,i_seg} each cycle with the previous synchronized value; any difference is a "change".
REQ-014 On change: SHALL go to SETTLE with count=0 if the new i_dig is one-hot, otherwise SHALL go to IDLE.
REQ-015 In SETTLE without change: count increments; when count reaches STABLE_CYCLES-1 the digit SHALL be captured on that edge and the state SHALL become CAPTURED.
REQ-016 In CAPTURED, no re-capture SHALL occur until a change.
REQ-017 In IDLE, no capture SHALL occur; non-one-hot i_dig (0000, 0110, ...) is never captured.
REQ-018 Timing: with inputs first sampled at edge k and held, o_bcd/o_dp/o_err for that digit SHALL update on edge k+STABLE_CYCLES+2.
REQ-019 Decode bits6:0: 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9, with err=0.
REQ-020 SHALL decode 0x00 (blank) to nibble 4'hF with err=0, and any other pattern to nibble 4'hE with err=1.
REQ-021 The dp bit SHALL be captured independently of the pattern decode and SHALL NOT affect o_err.
REQ-022 On capture, only the selected digit's nibble, dp bit and err bit SHALL change.
REQ-023 A 4-bit seen-mask SHALL OR in the captured digit; if the result is 4'hF, o_frame_valid SHALL pulse high on the next edge for exactly one cycle and the mask SHALL clear to 0.
REQ-024 Repeated captures of the same digit before the frame completes SHALL NOT pulse o_frame_valid.
REQ-025 When i_clear and a capture occur on the same edge, i_clear SHALL win: mask=0 and no pulse, while the digit data still updates.

Reset
REQ-026 While rst_n=0: o_bcd=16'hFFFF, o_dp=0, o_err=0, o_frame_valid=0, mask=0, state=IDLE, count=0, synchronizer flops=0.
REQ-027 Reset asserted mid-SETTLE or mid-frame SHALL abort immediately with no partial capture.
REQ-028 After rst_n rises, the first capture SHALL obey REQ-018 timing.

Structure
REQ-029 Package seg_pkg SHALL hold the ten digit pattern constants, SEG_BLANK=0x00, and the nibble codes BCD_BLANK=4'hF and BCD_ERR=4'hE; the state enum SHALL be local to the module.
REQ-030 Pattern-to-BCD lookup SHALL be one combinational sub-module, seg7_pattern_decode (in 7 bits; out nibble + err).

Verification
REQ-031 Hold i_dig=0001, i_seg=0x5B with STABLE_CYCLES=3 → o_bcd[3:0]=2, o_err[0]=0, update exactly 5 edges after first sample.
REQ-032 Scan digits 0..3 with 0x06,0x4F,0x66,0xED, 6 cycles each → o_bcd=16'h5431 (digit 3 = 5), o_dp=4'b1000, single o_frame_valid pulse after the digit-3 capture.
REQ-033 Toggle i_seg between 0x3F and 0x06 every 2 cycles for 20 cycles → no capture; o_bcd unchanged.
REQ-034 Digit 2 = 0x49 → nibble 2 = 4'hE, o_err=4'b0100; digit 2 = 0x00 → nibble 4'hF, err cleared.
REQ-035 Apply i_dig=0011 for 10 cycles → no capture; assert rst_n=0 mid-SETTLE → all outputs at REQ-026 values.
REQ-036 Assert i_clear on the same edge as the 4th-digit capture → no o_frame_valid pulse and mask=0.
